gf2_poly_divider: RTL
=====================

// Module: gf2_poly_divider
// PURPOSE
//  Bit-serial GF(2)[x] long divider: a(x) = q(x)*b(x) + r(x), deg r < deg b.
//  Inverse of the carry-less multiplier: consumes a 2N-bit product, returns quotient and remainder.
//  Used for product checking and reduction of multiplier output; one division in flight at a time.
// PARAMETERS
//  N  384  divisor width; dividend/quotient width 2N, remainder width N
// PORTS
//  clk          in   1    clock, all state updates on posedge
//  rst          in   1    synchronous, active-high reset
//  start        in   1    request; sampled only in IDLE
//  a            in   2N   dividend, captured on the accepting edge
//  b            in   N    divisor, captured on the accepting edge
//  busy         out  1    high in NORM and DIV
//  done         out  1    one-cycle pulse, results valid
//  div_by_zero  out  1    set with done when b==0; held until next accept
//  q            out  2N   quotient; held until next accept
//  r            out  N    remainder; held until next accept
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, div_by_zero=0; q, r=0. A mid-operation rst aborts; no done pulse.
//  FSM IDLE->NORM->DIV->DONE->IDLE. Accept = edge E0, where start=1 in IDLE.
//   At E0, load W<=a (2N bits), B<={N'b0,b}, Q<=0, s<=0. Then go to NORM.
//  NORM: B==0 -> DONE, div_by_zero<=1, q<=0, r<=0.
//   Else, if B[2N-1]==0, B<=B<<1 and s<=s+1; otherwise go to DIV with k=2N-1, cnt=s.
//   The loop ends with s = 2N-1-deg(b); NORM lasts s+1 edges.
//  DIV: each edge computes qb=W[k]; if qb then W<=W^B.
//   Q<={Q[2N-2:0],qb}, B<=B>>1, k<=k-1.
//   After s+1 edges, k==deg(b)-1, then go to DONE.
//  DONE: q<=Q, r<=W[N-1:0], done=1 for one cycle. Next state is IDLE.
//  Latency: done is high in the cycle after edge E0+2s+3, so it depends on data.
//   Range: s=N (deg b=N-1) up to s=2N-1 (b=1).
//   For b==0, done is high after edge E0+2.
//  start while busy or done: ignored, no queuing. Next accept is possible the cycle after done.
//  Inputs a and b may change freely after E0. Outputs change only on DONE or rst.
//  All arithmetic is XOR (no carries). The upper N bits of r-path W are zero at completion.
// CONFIGURATION
//  GF2_DIV_QUOTIENT_EN defined: Q register built and q driven as above.
//  Not defined: Q register and qb shift removed, q tied to 0.
//   r, done, div_by_zero and latency are identical in both builds.
// TESTING
//  a=0x1B, b=0x3 -> q=0x9, r=0, div_by_zero=0, done after edge E0+1535 (s=766).
//  a=0x13, b=0x3 -> q=0xE, r=0x1; without GF2_DIV_QUOTIENT_EN -> q=0, r=0x1.
//  a=random 768-bit, b=0x1 -> q=a, r=0, s=767 (maximum latency, edge E0+1537).
//  b=0, any a -> done after edge E0+2, div_by_zero=1, q=0, r=0.
//   Next accept with b=0x3 clears div_by_zero.
//  Round trip: c=a'*b' from the multiplier (random 384-bit a', b' with b'[383]=1), divide c by b'
//   -> q=a', r=0, s=384. Second accept is issued the cycle after done.
//  Assert rst mid-DIV, then start again with a=0x13, b=0x3
//   -> no done during abort, outputs 0, next result q=0xE, r=0x1.
//   start pulses while busy are ignored.

Source files
------------

// File: rtl/gf2_poly_divider_if.sv
// Request/result bundle for the bit-serial GF(2)[x] divider.
interface gf2_poly_divider_if #(parameter int N = 384);
  logic             start;
  logic [2*N-1:0]   a;
  logic [N-1:0]     b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [2*N-1:0]   q;
  logic [N-1:0]     r;

  modport master (output start, a, b, input busy, done, div_by_zero, q, r);
  modport slave  (input start, a, b, output busy, done, div_by_zero, q, r);
endinterface

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider, a = q*b + r. Define GF2_DIV_QUOTIENT_EN to build
// the quotient register; otherwise q is tied to zero and only r is produced.
module gf2_poly_divider #(
  parameter int N = 384
) (
  input  logic              clk,
  input  logic              rst,
  gf2_poly_divider_if.slave bus
);
  localparam int W2 = 2 * N;
  localparam int KW = $clog2(W2);

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t          state;
  logic [W2-1:0]   w;
  logic [W2-1:0]   bb;
  logic [KW-1:0]   s;
  logic [KW-1:0]   cnt;
  logic [KW-1:0]   k;
  logic            dz_pend;
  logic            busy_r;
  logic            done_r;
  logic            dz_r;
  logic [N-1:0]    r_r;
`ifdef GF2_DIV_QUOTIENT_EN
  logic [W2-1:0]   qacc;
  logic [W2-1:0]   q_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      w       <= '0;
      bb      <= '0;
      s       <= '0;
      cnt     <= '0;
      k       <= '0;
      dz_pend <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      r_r     <= '0;
`ifdef GF2_DIV_QUOTIENT_EN
      qacc    <= '0;
      q_r     <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // the done cycle itself is still IDLE but must not accept
          if (bus.start && !done_r) begin
            w       <= bus.a;
            bb      <= {{N{1'b0}}, bus.b};
            s       <= '0;
            dz_pend <= 1'b0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b1;
            state   <= NORM;
`ifdef GF2_DIV_QUOTIENT_EN
            qacc    <= '0;
`endif
          end
        end
        NORM: begin
          if (bb == '0) begin
            dz_pend <= 1'b1;
            busy_r  <= 1'b0;
            state   <= DONE;
          end else if (!bb[W2-1]) begin
            bb <= bb << 1;
            s  <= s + 1'b1;
          end else begin
            k     <= KW'(W2 - 1);
            cnt   <= s;
            state <= DIV;
          end
        end
        DIV: begin
          if (w[k]) w <= w ^ bb;
`ifdef GF2_DIV_QUOTIENT_EN
          qacc <= {qacc[W2-2:0], w[k]};
`endif
          bb <= bb >> 1;
          k  <= k - 1'b1;
          if (cnt == '0) begin
            busy_r <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          dz_r   <= dz_pend;
          r_r    <= dz_pend ? '0 : w[N-1:0];
`ifdef GF2_DIV_QUOTIENT_EN
          q_r    <= dz_pend ? '0 : qacc;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;
  assign bus.r           = r_r;
`ifdef GF2_DIV_QUOTIENT_EN
  assign bus.q           = q_r;
`else
  assign bus.q           = '0;
`endif
endmodule
